// File: rtl/uart_word_sender.sv
// uart_word_sender: serializes a BYTES-character word onto one UART line, MSB character first
module uart_word_sender #(
  parameter int CLK_FRE     = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_ON   = 0,
  parameter int PARITY_TYPE = 0,
  parameter int BYTES       = 4
) (
  input  logic                          i_clk_sys,
  input  logic                          i_rst,
  input  logic [BYTES*DATA_WIDTH-1:0]   i_data,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_uart_tx,
  output logic                          o_byte_done,
  output logic                          o_done
);
  localparam int DIV = CLK_FRE / BAUD_RATE;
  localparam int W   = BYTES * DATA_WIDTH;
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_WIDTH) + 1;
  localparam int YW  = $clog2(BYTES) + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic [YW-1:0]         byte_cnt;
  logic [W-1:0]          word;
  logic [DATA_WIDTH-1:0] bits;
  logic [DATA_WIDTH-1:0] chr;
  logic                  par;
  logic                  bit_end;
  assign chr     = word[W-1 -: DATA_WIDTH];
  assign par     = (^chr) ^ (PARITY_TYPE != 0);
  assign bit_end = cnt == CW'(DIV - 1);
  // Outputs are loaded with the value of the state being entered, so they stay registered
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      byte_cnt    <= '0;
      word        <= '0;
      bits        <= '0;
      o_busy      <= 1'b0;
      o_uart_tx   <= 1'b1;
      o_byte_done <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_byte_done <= 1'b0;
      o_done      <= 1'b0;
      cnt         <= bit_end ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt       <= '0;
          o_uart_tx <= 1'b1;
          o_busy    <= 1'b0;
          if (i_start) begin
            word      <= i_data;
            byte_cnt  <= '0;
            state     <= START;
            o_uart_tx <= 1'b0;
            o_busy    <= 1'b1;
          end
        end
        START: if (bit_end) begin
          state     <= DATA;
          bit_idx   <= '0;
          o_uart_tx <= chr[0];
          bits      <= chr >> 1;
        end
        DATA: if (bit_end) begin
          if (bit_idx == BW'(DATA_WIDTH - 1)) begin
            state     <= PARITY_ON != 0 ? PARITY : STOP;
            o_uart_tx <= PARITY_ON != 0 ? par : 1'b1;
          end else begin
            bit_idx   <= bit_idx + 1'b1;
            o_uart_tx <= bits[0];
            bits      <= bits >> 1;
          end
        end
        PARITY: if (bit_end) begin
          state     <= STOP;
          o_uart_tx <= 1'b1;
        end
        STOP: begin
          o_byte_done <= cnt == CW'(DIV - 2);
          if (bit_end) begin
            if (byte_cnt < YW'(BYTES - 1)) begin
              byte_cnt  <= byte_cnt + 1'b1;
              word      <= word << DATA_WIDTH;
              state     <= START;
              o_uart_tx <= 1'b0;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_word_sender.sv
// tb_uart_word_sender: directed + random words checked against a per-cycle line model and a UART decoder
module tb_uart_word_sender;
  localparam int DIV  = 4;
  localparam int C    = 10 * DIV;
  localparam int WORD = 4 * C;
  localparam int CP   = 11 * DIV;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, start, busy, tx, bd, done;
  logic [31:0] data;
  logic        pstart;
  logic [7:0]  pdata;
  logic        pe_busy, pe_tx, pe_bd, pe_done, po_busy, po_tx, po_bd, po_done;
  int          checks = 0;
  int          failures = 0;
  logic        obs [1:WORD];

  uart_word_sender #(.CLK_FRE(40), .BAUD_RATE(10), .DATA_WIDTH(8), .PARITY_ON(0), .PARITY_TYPE(0), .BYTES(4)) dut (
    .i_clk_sys(clk), .i_rst(rst), .i_data(data), .i_start(start),
    .o_busy(busy), .o_uart_tx(tx), .o_byte_done(bd), .o_done(done));
  uart_word_sender #(.CLK_FRE(40), .BAUD_RATE(10), .DATA_WIDTH(8), .PARITY_ON(1), .PARITY_TYPE(0), .BYTES(1)) dut_pe (
    .i_clk_sys(clk), .i_rst(rst), .i_data(pdata), .i_start(pstart),
    .o_busy(pe_busy), .o_uart_tx(pe_tx), .o_byte_done(pe_bd), .o_done(pe_done));
  uart_word_sender #(.CLK_FRE(40), .BAUD_RATE(10), .DATA_WIDTH(8), .PARITY_ON(1), .PARITY_TYPE(1), .BYTES(1)) dut_po (
    .i_clk_sys(clk), .i_rst(rst), .i_data(pdata), .i_start(pstart),
    .o_busy(po_busy), .o_uart_tx(po_tx), .o_byte_done(po_bd), .o_done(po_done));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line level expected in cycle n (1-based after acceptance) for a word of nb characters
  function automatic logic exp_bit(input logic [31:0] w, input int nb, input int pon, input int pty, input int n);
    int c, k, s;
    logic [7:0] b;
    c = (10 + pon) * DIV;
    k = (n - 1) / c;
    s = ((n - 1) % c) / DIV;
    b = 8'(w >> (8 * (nb - 1 - k)));
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if (pon != 0 && s == 9) return (^b) ^ pty[0];
    return 1'b1;
  endfunction

  task automatic begin_word(input logic [31:0] w);
    data  = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_word(input logic [31:0] w, input int poke, input int abort_at, input bit hold, input logic [31:0] next_w);
    int i, k;
    logic [7:0] b;
    for (int n = 1; n <= WORD; n++) begin
      chk("tx", 32'(tx), 32'(exp_bit(w, 4, 0, 0, n)));
      chk("busy", 32'(busy), 1);
      chk("byte_done", 32'(bd), 32'(n % C == 0));
      chk("done_early", 32'(done), 0);
      obs[n] = tx;
      start = (n == poke) || hold;
      if (n == poke) data = 32'hFFFF_FFFF;
      if (hold && n == 1) data = next_w;
      if (n == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        repeat (2 * C) begin
          @(negedge clk);
          chk("post_rst_tx", 32'(tx), 1);
          chk("post_rst_done", 32'(done), 0);
        end
        return;
      end
      @(negedge clk);
    end
    chk("done", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_tx", 32'(tx), 1);
    chk("done_bd", 32'(bd), 0);
    i = 1;
    k = 0;
    while (i <= WORD) begin
      if (obs[i] === 1'b0 && i + 9 * DIV + DIV / 2 <= WORD) begin
        for (int j = 0; j < 8; j++) b[j] = obs[i + DIV * (j + 1) + DIV / 2];
        if (k < 4) chk("decode_byte", 32'(b), 32'(8'(w >> (24 - 8 * k))));
        chk("decode_stop", 32'(obs[i + 9 * DIV + DIV / 2]), 1);
        k++;
        i += C;
      end else i++;
    end
    chk("decode_count", k, 4);
  endtask

  task automatic par_word(input logic [7:0] b);
    pdata  = b;
    pstart = 1'b1;
    @(negedge clk);
    pstart = 1'b0;
    for (int n = 1; n <= CP; n++) begin
      chk("pe_tx", 32'(pe_tx), 32'(exp_bit({24'b0, b}, 1, 1, 0, n)));
      chk("po_tx", 32'(po_tx), 32'(exp_bit({24'b0, b}, 1, 1, 1, n)));
      chk("pe_bd", 32'(pe_bd), 32'(n == CP));
      chk("po_bd", 32'(po_bd), 32'(n == CP));
      chk("pe_busy", 32'(pe_busy), 1);
      @(negedge clk);
    end
    chk("pe_done", 32'(pe_done), 1);
    chk("po_done", 32'(po_done), 1);
    chk("pe_done_busy", 32'(pe_busy), 0);
  endtask

  initial begin
    logic [31:0] r2, r3;
    rst = 1'b1; start = 1'b0; data = '0; pstart = 1'b0; pdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_bd", 32'(bd), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_pe_tx", 32'(pe_tx), 1);
    rst = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      chk("idle_tx", 32'(tx), 1);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_pulses", 32'({bd, done}), 0);
    end
    begin_word(32'h1234_5678);
    check_word(32'h1234_5678, 0, 0, 1'b0, 0);
    begin_word(32'h1234_5678);
    check_word(32'h1234_5678, 50, 0, 1'b0, 0);
    @(negedge clk);
    chk("single_done", 32'(done), 0);
    begin_word(32'h1234_5678);
    check_word(32'h1234_5678, 0, 57, 1'b0, 0);
    begin_word(32'h1234_5678);
    check_word(32'h1234_5678, 0, 0, 1'b0, 0);
    r2 = $urandom;
    r3 = $urandom;
    begin_word(r2);
    check_word(r2, 0, 0, 1'b1, r3);
    @(negedge clk);
    check_word(r3, 0, 0, 1'b0, 0);
    repeat (3) begin
      r2 = $urandom;
      begin_word(r2);
      check_word(r2, 0, 0, 1'b0, 0);
    end
    par_word(8'h07);
    par_word(8'($urandom));
    par_word(8'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_word_sender.md
# uart_word_sender

Self-contained UART transmit engine that takes a multi-byte word and serializes it onto one UART line, most significant character first. It is the transmit-side counterpart of the byte-assembling receive path. It returns CPU results (e.g. the 32-bit `Res`) to the host without an external byte sequencer. It contains its own baud counter, character framing FSM and word-level byte counter.

## Interface
- `CLK_FRE`, 100000000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line rate; `DIV = CLK_FRE / BAUD_RATE` (integer division), legal only if `DIV >= 2`
- `DATA_WIDTH`, 8, data bits per character
- `PARITY_ON`, 0, 1 = append parity bit, 0 = none
- `PARITY_TYPE`, 0, 1 = odd, 0 = even
- `BYTES`, 4, characters per word
- `i_clk_sys`  in  1  system clock, rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_data`  in  BYTES*DATA_WIDTH  word to send; sampled only when a start is accepted
- `i_start`  in  1  request; accepted in any cycle where `o_busy`=0
- `o_busy`  out  1  high from the cycle after acceptance until the word completes
- `o_uart_tx`  out  1  serial line, idle high
- `o_byte_done`  out  1  one-cycle pulse per character sent
- `o_done`  out  1  one-cycle pulse when the whole word is sent

## Operation
- Reset values: `o_uart_tx`=1, `o_busy`=0, `o_byte_done`=0, `o_done`=0. The FSM is in IDLE and all counters are 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On `i_start`=1, latch `i_data` into the shift register and clear the byte counter.
  - Go to START.
- START: drive 0 for DIV cycles, then go to DATA.
- DATA:
  - Drive character bits LSB first, DIV cycles each, DATA_WIDTH bits.
  - Then go to PARITY if `PARITY_ON`=1, otherwise to STOP.
- PARITY:
  - Even type: the bit is the XOR of the character's data bits.
  - Odd type: the bit is the inverse of that XOR.
  - Drive it for DIV cycles, then go to STOP.
- STOP:
  - Drive 1 for DIV cycles.
  - `o_byte_done`=1 in the last STOP cycle.
  - If the byte counter is below BYTES-1: increment it, shift the word left by DATA_WIDTH, go to START. There is no idle gap between characters.
  - Otherwise go to IDLE.
- Character order: the first character is `i_data[BYTES*DATA_WIDTH-1 -: DATA_WIDTH]`, the last is `i_data[DATA_WIDTH-1:0]`.
- Baud counter:
  - Counts 0..DIV-1 and wraps.
  - It is cleared on start acceptance and on every state transition, so each bit lasts exactly DIV cycles.
- `i_start` while `o_busy`=1 is ignored; the latched word is not disturbed.
- Changes on `i_data` after acceptance have no effect.
- `i_rst`=1 in any state, including mid-character:
  - Next cycle: line =1, `o_busy`=0, no `o_done` pulse.
  - The partial word is discarded.

## Timing
- Acceptance edge E0 (IDLE, `i_start`=1):
  - From the cycle after E0: `o_busy`=1 and the start bit is on the line.
  - Latency from request to line activity: 1 cycle.
- Character length `C = (2 + DATA_WIDTH + PARITY_ON) * DIV` cycles.
- Word length `BYTES * C` cycles.
- After the last STOP cycle the FSM is in IDLE:
  - `o_done`=1 and `o_busy`=0 for exactly that first IDLE cycle.
  - `i_start` in that same cycle is accepted, giving back-to-back words with the line held 1 for that single cycle.
- `o_byte_done` and `o_done` never assert in the same cycle. `o_done` follows the final `o_byte_done` by 1 cycle.
- All outputs are registered.

## Test plan
- Params CLK_FRE=40, BAUD_RATE=10 (DIV=4), BYTES=4, no parity, `i_data`=0x12345678, one-cycle `i_start`:
  - Line 0 for 4 cycles, then bits 0,1,0,0,1,0,0,0 (0x12), then stop.
  - Continues with 0x34, 0x56, 0x78.
  - `o_byte_done` at cycles 40, 80, 120, 160 after E0; `o_done` at 161.
  - The bench UART model decodes 12 34 56 78.
- PARITY_ON=1, PARITY_TYPE=0, BYTES=1, data 0x07:
  - Parity bit 1, character 44 cycles.
  - With PARITY_TYPE=1 the parity bit is 0.
- `i_start` pulsed at cycle 50 of a word with `i_data` changed to 0xFFFFFFFF: ignored; the line still carries 0x12345678 and `o_done` fires once.
- `i_rst` asserted at cycle 57 mid-word:
  - `o_uart_tx`=1 and `o_busy`=0 the next cycle; no `o_done`.
  - A new `i_start` then sends a full fresh word.
- `i_start` held high continuously with two words: the second start bit begins exactly 1 cycle after the `o_done` cycle; both words decode correctly.
- Line idle check: with no start for 1000 cycles after reset, `o_uart_tx` stays 1 and all pulses stay 0.
